// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op codes (common with the decoder)
// and the handshake FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative unit: one-bit-per-cycle shifter and shift-add multiplier.
// result/carry present the value after the current step, valid while done is high.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int unsigned CW = SHW + 1;

  logic             busy_q, busy_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             sh_out_q, sh_out_d;
  logic [WIDTH:0]   psum;

  always_comb begin
    busy_d   = busy_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    sh_out_d = sh_out_q;
    psum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});

    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      case (op_q)
        OP_SHL:  {sh_out_d, lo_d} = {lo_q, 1'b0};
        OP_SHR:  {lo_d, sh_out_d} = {1'b0, lo_q};
        // {hi,lo} is the running product; lo shifts the multiplier out bit by bit
        default: {hi_d, lo_d} = {psum, lo_q[WIDTH-1:1]};
      endcase
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end

    if (start) begin
      busy_d   = 1'b1;
      op_d     = op;
      mcand_d  = a;
      hi_d     = '0;
      sh_out_d = 1'b0;
      if (op == OP_MUL) begin
        lo_d  = b;
        cnt_d = CW'(WIDTH);
      end else begin
        lo_d  = a;
        cnt_d = {1'b0, b[SHW-1:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      op_q     <= 3'd0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      sh_out_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      sh_out_q <= sh_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == CW'(1));
  assign result = lo_d;
  assign carry  = (op_q == OP_MUL) ? |hi_d : sh_out_d;

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: valid/ready handshake FSM, single-cycle datapath, and an
// iterative unit for shifts and multiply. Result and flags are registered.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             out_valid,
  input  logic             out_ready
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  logic             accept;
  logic             needs_iter;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  logic             iter_start;
  logic             iter_busy;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;
  logic             iter_carry;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // A zero shift amount completes in one cycle like the logic ops.
  assign needs_iter = (alu_op == OP_MUL) || (is_shift_op(alu_op) && (b[SHW-1:0] != '0));

  always_comb begin
    sum_ext   = {1'b0, a} + {1'b0, b};
    diff_ext  = {1'b0, a} - {1'b0, b};
    alu_res   = a;
    alu_carry = 1'b0;
    case (alu_op)
      OP_ADD:  {alu_carry, alu_res} = sum_ext;
      OP_SUB:  {alu_carry, alu_res} = diff_ext;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    iter_start = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (needs_iter) begin
            state_d    = ST_BUSY;
            iter_start = 1'b1;
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
          end
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          state_d  = ST_DONE;
          result_d = iter_result;
          zero_d   = (iter_result == '0);
          carry_d  = iter_carry;
        end else if (!iter_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  alu_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .op     (alu_op),
    .a      (a),
    .b      (b),
    .busy   (iter_busy),
    .done   (iter_done),
    .result (iter_result),
    .carry  (iter_carry)
  );

  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign out_valid  = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: vector table through a scoreboard, plus
// backpressure, streaming and mid-operation reset sequences.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   alu_op;
  logic [W-1:0] a, b;
  logic         in_valid, in_ready;
  logic [W-1:0] result;
  logic         flag_zero, flag_carry, out_valid, out_ready;

  alu_exec #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_op     (alu_op),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   front_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(logic [2:0] op, logic [W-1:0] va, logic [W-1:0] vb,
                              logic [W-1:0] res, logic z, logic c, int lat);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = res; v.z = z; v.c = c; v.lat = lat;
    return v;
  endfunction

  // Holds the request until accepted, then scrambles inputs to show they are not reused.
  task automatic send(input vec_t v, output int waits, output int acc_at);
    exp_t e;
    waits  = 0;
    acc_at = -1;
    alu_op   = v.op;
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
    while (acc_at < 0) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = v.res; e.z = v.z; e.c = v.c; e.lat = v.lat; e.acc_cyc = cyc;
        sb.push_back(e);
        acc_at = cyc;
      end else begin
        waits++;
        if (waits > 100) begin
          check("accept_timeout", waits, 0);
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op   = 3'($urandom);
    a        = W'($urandom);
    b        = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: latency on first sight of out_valid, values on transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      front_seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid_sb_depth", sb.size(), 1);
      end else begin
        if (!front_seen) begin
          check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
          front_seen = 1'b1;
        end
        if (out_ready) begin
          check("result", result, sb[0].res);
          check("flag_zero", flag_zero, sb[0].z);
          check("flag_carry", flag_carry, sb[0].c);
          void'(sb.pop_front());
          front_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, at;
    int acc[4];

    vecs.push_back(mk(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1));
    vecs.push_back(mk(OP_SUB, 16'd3,    16'd5,    16'hFFFE, 1'b0, 1'b1, 1));
    vecs.push_back(mk(OP_AND, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 1));
    vecs.push_back(mk(OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1));
    vecs.push_back(mk(OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1));
    vecs.push_back(mk(OP_SUB, 16'd5,    16'd5,    16'h0000, 1'b1, 1'b0, 1));
    vecs.push_back(mk(OP_SHL, 16'h8001, 16'd4,    16'h0010, 1'b0, 1'b0, 5));
    vecs.push_back(mk(OP_SHR, 16'h0003, 16'd1,    16'h0001, 1'b0, 1'b1, 2));
    vecs.push_back(mk(OP_SHL, 16'h1234, 16'd0,    16'h1234, 1'b0, 1'b0, 1));
    vecs.push_back(mk(OP_SHL, 16'hFFFF, 16'h0013, 16'hFFF8, 1'b0, 1'b1, 4));
    vecs.push_back(mk(OP_SHR, 16'h8000, 16'd15,   16'h0001, 1'b0, 1'b0, 16));
    vecs.push_back(mk(OP_MUL, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b1, 17));
    vecs.push_back(mk(OP_MUL, 16'd7,    16'd6,    16'd42,   1'b0, 1'b0, 17));
    vecs.push_back(mk(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 17));

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = OP_ADD;
    a         = '0;
    b         = '0;

    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flag_zero", flag_zero, 0);
    check("reset_flag_carry", flag_carry, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) send(vecs[i], w, at);
    drain();

    // Backpressure: result held while out_ready is low, then same-cycle accept.
    out_ready = 1'b0;
    send(mk(OP_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 1), w, at);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_result_stable", result, 16'h0FF0);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(mk(OP_ADD, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0, 1), w, at);
    check("bp_same_cycle_accept_waits", w, 0);
    drain();

    // Stream of single-cycle ops: one accept per cycle.
    for (int i = 0; i < 4; i++) begin
      send(mk(OP_XOR, W'(16'h1111 * (i + 1)), 16'h00F0,
              W'(16'h1111 * (i + 1)) ^ 16'h00F0, 1'b0, 1'b0, 1), w, at);
      acc[i] = at;
    end
    for (int i = 1; i < 4; i++) check("stream_spacing", acc[i] - acc[i-1], 1);
    drain();

    // Reset in the middle of a multiply.
    send(mk(OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1), w, at);
    drain();
    send(mk(OP_MUL, 16'd300, 16'd300, 16'h5F90, 1'b0, 1'b1, 17), w, at);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flag_zero", flag_zero, 0);
    check("midrst_flag_carry", flag_carry, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_no_stale_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send(mk(OP_ADD, 16'd2, 16'd2, 16'd4, 1'b0, 1'b0, 1), w, at);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
